// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating accumulator of NUM_TERMS int8 products with valid/ready result port
module product_accumulator #(
    parameter int NUM_TERMS = 4,   // products summed per result, 1..255
    parameter int ACC_WIDTH = 16   // accumulator/result width, >= 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_product,
    input  logic                 in_overflow,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_prod_ovf,
    output logic                 out_sat
);

    // Counter sized so it can represent 0..NUM_TERMS.
    localparam int CNT_W = $clog2(NUM_TERMS + 1);

    // Count value at which the accepted term is the last one of a result.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

    // Largest representable sum; the accumulator pins here once it overflows.
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    typedef enum logic {
        ST_ACCUM = 1'b0,   // taking terms
        ST_HOLD  = 1'b1    // result presented, waiting for consumer
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 prod_ovf_q, prod_ovf_d;
    logic                 sat_q, sat_d;

    // One extra bit of headroom exposes the carry used for saturation.
    logic [ACC_WIDTH:0]   sum_ext;

    // Next-state logic: accept terms in ACCUM, hold the result until handshake.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        prod_ovf_d = prod_ovf_q;
        sat_d      = sat_q;
        sum_ext    = {1'b0, acc_q} + {{(ACC_WIDTH - 7){1'b0}}, in_product};

        case (state_q)
            ST_ACCUM: begin
                // in_ready is 1 in this state, so in_valid alone qualifies the accept.
                // The truncated product is added even when its overflow flag is set.
                if (in_valid) begin
                    if (sum_ext[ACC_WIDTH]) begin
                        acc_d = ACC_MAX;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[ACC_WIDTH-1:0];
                    end
                    prod_ovf_d = prod_ovf_q | in_overflow;
                    if (count_q == LAST_CNT) begin
                        count_d = CNT_W'(NUM_TERMS);
                        state_d = ST_HOLD;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                // Delivery clears everything; no term is taken in this cycle.
                if (out_ready) begin
                    acc_d      = '0;
                    count_d    = '0;
                    prod_ovf_d = 1'b0;
                    sat_d      = 1'b0;
                    state_d    = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial or pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACCUM;
            acc_q      <= '0;
            count_q    <= '0;
            prod_ovf_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            prod_ovf_q <= prod_ovf_d;
            sat_q      <= sat_d;
        end
    end

    // Handshake flags depend only on state; outputs are the running registers,
    // which stay frozen while in HOLD.
    always_comb begin
        in_ready     = (state_q == ST_ACCUM);
        out_valid    = (state_q == ST_HOLD);
        out_sum      = acc_q;
        out_prod_ovf = prod_ovf_q;
        out_sat      = sat_q;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed self-checking bench for product_accumulator
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst9;
    logic        in_valid;
    logic [7:0]  in_product;
    logic        in_overflow;
    logic        out_ready;

    logic        in_ready, out_valid, out_prod_ovf, out_sat;
    logic [15:0] out_sum;
    logic        in_ready9, out_valid9, out_prod_ovf9, out_sat9;
    logic [8:0]  out_sum9;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_product   (in_product),
        .in_overflow  (in_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_prod_ovf (out_prod_ovf),
        .out_sat      (out_sat)
    );

    product_accumulator #(.NUM_TERMS(4), .ACC_WIDTH(9)) dut9 (
        .clk          (clk),
        .rst          (rst9),
        .in_valid     (in_valid),
        .in_ready     (in_ready9),
        .in_product   (in_product),
        .in_overflow  (in_overflow),
        .out_valid    (out_valid9),
        .out_ready    (out_ready),
        .out_sum      (out_sum9),
        .out_prod_ovf (out_prod_ovf9),
        .out_sat      (out_sat9)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed four back-to-back terms; p[7:0] is the first term.
    task automatic run_block(input string tag, input logic [31:0] p, input logic [3:0] ovf);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_in_ready"}, in_ready, 1);
            in_valid    = 1'b1;
            in_product  = p[8*i +: 8];
            in_overflow = ovf[i];
            step();
        end
        in_valid    = 1'b0;
        in_overflow = 1'b0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
        check({tag, "_sum_clear"}, out_sum, 0);
    endtask

    initial begin
        rst = 1'b1; rst9 = 1'b1;
        in_valid = 1'b0; in_product = 8'd0; in_overflow = 1'b0; out_ready = 1'b0;
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_sum", out_sum, 0);
        check("rst_flags", {out_prod_ovf, out_sat}, 0);
        rst = 1'b0;
        step();

        // Block 5,10,25,250 with in_valid held through the handshake cycle.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_product = 8'd5;   step();
        in_product = 8'd10;  step();
        in_product = 8'd25;  step();
        check("t1_no_valid_early", out_valid, 0);
        in_product = 8'd250; step();
        check("t1_valid", out_valid, 1);
        check("t1_sum", out_sum, 290);
        check("t1_flags", {out_prod_ovf, out_sat}, 0);
        check("t1_in_ready_low", in_ready, 0);
        in_product = 8'd9;   step();
        check("t1_valid_drop", out_valid, 0);
        check("t1_sum_restart", out_sum, 0);
        check("t1_in_ready_back", in_ready, 1);
        in_valid = 1'b0;
        out_ready = 1'b0;

        // Overflowed product is summed as truncated; flag clears with delivery.
        run_block("t2a", {8'd1, 8'd1, 8'd19, 8'd5}, 4'b0010);
        check("t2a_valid", out_valid, 1);
        check("t2a_sum", out_sum, 26);
        check("t2a_ovf", out_prod_ovf, 1);
        check("t2a_sat", out_sat, 0);
        handshake("t2a");
        run_block("t2b", {8'd1, 8'd1, 8'd1, 8'd1}, 4'b0000);
        check("t2b_sum", out_sum, 4);
        check("t2b_ovf", out_prod_ovf, 0);
        handshake("t2b");

        // 9-bit accumulator saturation, run alongside the 16-bit instance.
        rst9 = 1'b0;
        in_valid = 1'b1;
        in_product = 8'd250; step();
        in_product = 8'd250; step();
        check("t3_sum9_500", out_sum9, 500);
        check("t3_sat9_pre", out_sat9, 0);
        in_product = 8'd25;  step();
        check("t3_sum9_clip", out_sum9, 511);
        check("t3_sat9_mid", out_sat9, 1);
        in_product = 8'd1;   step();
        in_valid = 1'b0;
        check("t3_valid9", out_valid9, 1);
        check("t3_sum9", out_sum9, 511);
        check("t3_sat9", out_sat9, 1);
        check("t3_ovf9", out_prod_ovf9, 0);
        check("t3_sum16", out_sum, 526);
        check("t3_sat16", out_sat, 0);
        handshake("t3");
        check("t3_sum9_clear", out_sum9, 0);
        check("t3_sat9_clear", out_sat9, 0);
        rst9 = 1'b1;

        // Back-pressure: result must stay frozen and no term may enter.
        run_block("t4a", {8'd4, 8'd3, 8'd2, 8'd1}, 4'b0000);
        in_valid = 1'b1;
        in_product = 8'd7;
        for (int c = 0; c < 5; c++) begin
            check("t4_in_ready_low", in_ready, 0);
            check("t4_valid_held", out_valid, 1);
            check("t4_sum_stable", out_sum, 10);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t4_valid_drop", out_valid, 0);
        check("t4_sum_clear", out_sum, 0);
        step(); step(); step();
        check("t4_no_valid_early", out_valid, 0);
        step();
        in_valid = 1'b0;
        check("t4_valid2", out_valid, 1);
        check("t4_sum2", out_sum, 28);
        handshake("t4b");

        // Bubbles: 3,_,_,4,_,5,6.
        in_valid = 1'b1; in_product = 8'd3; step();
        in_valid = 1'b0; in_product = 8'd99; step(); step();
        in_valid = 1'b1; in_product = 8'd4; step();
        in_valid = 1'b0; in_product = 8'd77; step();
        in_valid = 1'b1; in_product = 8'd5; step();
        check("t5_sum_partial", out_sum, 12);
        check("t5_no_valid_early", out_valid, 0);
        in_product = 8'd6; step();
        in_valid = 1'b0;
        check("t5_valid", out_valid, 1);
        check("t5_sum", out_sum, 18);
        handshake("t5");

        // Reset mid-accumulation discards the partial sum.
        in_valid = 1'b1; in_product = 8'd100; step(); step();
        in_valid = 1'b0;
        check("t6_partial", out_sum, 200);
        rst = 1'b1; step(); rst = 1'b0;
        check("t6_rst_sum", out_sum, 0);
        run_block("t6a", {8'd1, 8'd1, 8'd1, 8'd1}, 4'b0000);
        check("t6a_valid", out_valid, 1);
        check("t6a_sum", out_sum, 4);
        check("t6a_flags", {out_prod_ovf, out_sat}, 0);
        handshake("t6a");

        // Reset while a result is pending: it is never delivered.
        run_block("t6b", {8'd4, 8'd3, 8'd2, 8'd1}, 4'b0000);
        check("t6b_valid", out_valid, 1);
        rst = 1'b1; step(); rst = 1'b0;
        check("t6b_valid_gone", out_valid, 0);
        check("t6b_sum_gone", out_sum, 0);
        check("t6b_in_ready", in_ready, 1);

        // Unknown inputs while in_valid is low leave the state untouched.
        in_valid = 1'b1; in_product = 8'd9; step();
        in_valid = 1'b0; in_product = 8'hxx; in_overflow = 1'bx;
        step(); step();
        check("t7_sum_hold", out_sum, 9);
        check("t7_ovf_hold", out_prod_ovf, 0);
        in_overflow = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of multiplier_int8: consumes its 8-bit unsigned product and overflow flag, one term per valid/ready transfer.
- Sums NUM_TERMS consecutive products into an ACC_WIDTH-bit saturating accumulator.
- Presents the sum, a sticky product-overflow flag and a saturation flag on a valid/ready output port.
- Forms the accumulate half of the int8 multiply-accumulate (dot-product) path.

Parameters:
- NUM_TERMS, 4, products summed per result; legal range 1..255.
- ACC_WIDTH, 16, accumulator/result width in bits; must be >= 8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_product/in_overflow valid this cycle.
- in_ready  output  1  block accepts a term this cycle.
- in_product  input  8  unsigned product (multiplier_int8 y).
- in_overflow  input  1  overflow flag of that product (multiplier_int8 overflow).
- out_valid  output  1  result held on out_* is valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  ACC_WIDTH  accumulated sum, zero-extended product terms.
- out_prod_ovf  output  1  at least one accepted term had in_overflow=1.
- out_sat  output  1  accumulator saturated during this result.

Behaviour:
- Reset (rst=1 at posedge): state=ACCUM, acc=0, term count=0, both sticky flags=0, out_valid=0, out_sum=0, out_prod_ovf=0, out_sat=0. Reset has priority over every other event, including mid-accumulation and with out_valid=1; any partial sum or undelivered result is discarded.
- States: ACCUM and HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready at posedge.
  - On accept: acc <= sat_add(acc, zero-extended in_product); prod_ovf <= prod_ovf | in_overflow; count <= count+1.
  - The truncated in_product is still added when in_overflow=1.
  - in_valid=0 cycles are bubbles: no state change.
- sat_add: compute with one extra bit. If the result exceeds 2^ACC_WIDTH-1, acc <= 2^ACC_WIDTH-1 and sat <= 1. Once saturated, acc stays at max until the result is delivered.
- Accepting term number NUM_TERMS:
  - Next state HOLD. out_valid=1 from the following cycle.
  - out_sum/out_prod_ovf/out_sat reflect all NUM_TERMS terms, including the final one.
  - Latency: final accept edge to out_valid high is 1 cycle.
- HOLD:
  - in_ready=0. out_valid=1.
  - out_sum, out_prod_ovf and out_sat remain stable until the handshake.
  - Handshake = out_valid & out_ready at posedge. On handshake: acc, count and flags clear to 0; state returns to ACCUM; out_valid=0 next cycle. in_ready=1 in that next cycle.
  - No term is accepted in the handshake cycle, so there is one bubble per result (throughput NUM_TERMS+1 cycles per result, minimum).
- out_* registers:
  - In ACCUM, out_sum/out_prod_ovf/out_sat track the running acc/flags.
  - Consumers must sample them only when out_valid=1.
- in_ready depends only on state, never combinationally on in_valid.
- NUM_TERMS=1: every accepted term immediately produces a result.
- Counter width $clog2(NUM_TERMS+1). Count never exceeds NUM_TERMS.
- X on in_product/in_overflow while in_valid=0 must not affect state.

Test Plan:
- Default params, terms 5,10,25,250 with in_valid held high, out_ready=1 -> out_valid exactly 1 cycle after the 4th accept; out_sum=290, out_prod_ovf=0, out_sat=0. in_ready low for 1 cycle, then the next block starts at sum 0.
- Terms 5, 19 (in_overflow=1, truncated value of 11*25), 1, 1 -> out_sum=26, out_prod_ovf=1, out_sat=0. Following block 1,1,1,1 -> out_sum=4, out_prod_ovf=0 (flags cleared).
- ACC_WIDTH=9, terms 250,250,25,1 -> acc 250, 500, saturates at the 3rd term; out_sum=511, out_sat=1, out_prod_ovf=0.
- Back-pressure: block 1,2,3,4 completes and out_ready is held 0 for 5 cycles while in_valid stays 1 with product 7 -> in_ready=0 throughout, out_sum stable at 10. On out_ready=1, handshake occurs; the next result (four 7s) is 28.
- Bubbles: terms 3,_,_,4,_,5,6 (_ = in_valid 0) -> out_sum=18. out_valid rises 1 cycle after the term 6 accept.
- Reset mid-operation: accept 100,100, then rst=1 for 1 cycle, then terms 1,1,1,1 -> out_sum=4, flags 0. Also rst asserted while out_valid=1 -> out_valid=0 next cycle, result never handshaken.
